// File: rtl/dac_spi_writer.sv
// Serialises one 12-bit sample per load strobe into a 32-bit SPI mode-0
// write frame for the external quad DAC; reports busy, done and overrun.
module dac_spi_writer #(
   parameter int unsigned CLK_DIV = 1,
   parameter logic [3:0]  CMD     = 4'b0011,
   parameter logic [3:0]  ADDR    = 4'b1111
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [11:0] sample,
   output logic        dac_cs_n,
   output logic        dac_sclk,
   output logic        dac_mosi,
   output logic        busy,
   output logic        done,
   output logic        overrun
);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DONE} state_t;

   localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

   state_t      state;
   logic [3:0]  div_cnt;
   logic [4:0]  bit_cnt;
   logic [30:0] shreg;
   logic [31:0] word;

   assign word = {8'h00, CMD, ADDR, sample, 4'h0};

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         dac_cs_n <= 1'b1;
         dac_sclk <= 1'b0;
         dac_mosi <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               // Accepting in DONE gives exactly one cycle of cs high between frames.
               if (load) begin
                  state    <= SHIFT;
                  shreg    <= word[30:0];
                  dac_mosi <= word[31];
                  dac_cs_n <= 1'b0;
                  dac_sclk <= 1'b0;
                  busy     <= 1'b1;
                  div_cnt  <= '0;
                  bit_cnt  <= 5'd31;
               end else begin
                  state    <= IDLE;
                  dac_cs_n <= 1'b1;
                  dac_mosi <= 1'b0;
                  busy     <= 1'b0;
               end
            end
            SHIFT: begin
               if (load) overrun <= 1'b1;
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (!dac_sclk) begin
                     dac_sclk <= 1'b1;
                  end else begin
                     // Data only moves as sclk falls, keeping it stable at the rising edge.
                     dac_sclk <= 1'b0;
                     if (bit_cnt == 5'd0) begin
                        state <= HOLD;
                     end else begin
                        bit_cnt  <= bit_cnt - 5'd1;
                        dac_mosi <= shreg[30];
                        shreg    <= {shreg[29:0], 1'b0};
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 4'd1;
               end
            end
            HOLD: begin
               if (load) overrun <= 1'b1;
               if (div_cnt == DIV_LAST) begin
                  state    <= DONE;
                  div_cnt  <= '0;
                  dac_cs_n <= 1'b1;
                  dac_mosi <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end else begin
                  div_cnt <= div_cnt + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dac_spi_writer.sv
// Directed bench for dac_spi_writer: one instance at CLK_DIV=1, one at CLK_DIV=3.
module tb_dac_spi_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic        sel = 1'b0;
   logic [11:0] sample = '0;

   logic cs_a, sclk_a, mosi_a, busy_a, done_a, ovr_a;
   logic cs_b, sclk_b, mosi_b, busy_b, done_b, ovr_b;
   logic cs_n, sclk, mosi, busy, done, ovr;

   always #5 clk = ~clk;

   dac_spi_writer #(.CLK_DIV(1)) dut_a (
      .clk(clk), .rst(rst), .load(load & ~sel), .sample(sample),
      .dac_cs_n(cs_a), .dac_sclk(sclk_a), .dac_mosi(mosi_a),
      .busy(busy_a), .done(done_a), .overrun(ovr_a));

   dac_spi_writer #(.CLK_DIV(3)) dut_b (
      .clk(clk), .rst(rst), .load(load & sel), .sample(sample),
      .dac_cs_n(cs_b), .dac_sclk(sclk_b), .dac_mosi(mosi_b),
      .busy(busy_b), .done(done_b), .overrun(ovr_b));

   assign cs_n = sel ? cs_b   : cs_a;
   assign sclk = sel ? sclk_b : sclk_a;
   assign mosi = sel ? mosi_b : mosi_a;
   assign busy = sel ? busy_b : busy_a;
   assign done = sel ? done_b : done_a;
   assign ovr  = sel ? ovr_b  : ovr_a;

   int unsigned total = 0;
   int unsigned passed = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
      else passed++;
   endtask

   logic [31:0] word;
   int          cs_len, edges, hi_max, lo_max, hi_total, dones_mid;
   logic        done_end, gap_ok;

   // Runs one frame, sampling mosi at every rising sclk seen on falling clk.
   task automatic frame(input logic do_load, input logic [11:0] smp,
                        input int ovr_at, input int rst_edge,
                        input logic b2b, input logic [11:0] smp2);
      logic prev;
      int   hi_run, lo_run;
      logic rst_hit;
      if (do_load) begin
         sample = smp;
         load   = 1'b1;
         @(negedge clk);
         load   = 1'b0;
      end
      word = '0; cs_len = 0; edges = 0; hi_max = 0; lo_max = 0; hi_total = 0;
      dones_mid = 0; prev = 1'b0; hi_run = 0; lo_run = 0; rst_hit = 1'b0;
      while (cs_n == 1'b0 && cs_len < 1000) begin
         cs_len++;
         if (done) dones_mid++;
         if (sclk) begin
            hi_run++; hi_total++; lo_run = 0;
            if (hi_run > hi_max) hi_max = hi_run;
            if (!prev) begin
               edges++;
               word = {word[30:0], mosi};
            end
         end else begin
            lo_run++; hi_run = 0;
            if (lo_run > lo_max) lo_max = lo_run;
         end
         prev = sclk;
         if (ovr_at != 0 && cs_len == ovr_at) begin
            check("ovr_before", {31'b0, ovr}, 32'd0);
            sample = 12'hFFF;
            load   = 1'b1;
         end else if (ovr_at != 0 && cs_len == ovr_at + 1) begin
            check("ovr_next_cycle", {31'b0, ovr}, 32'd1);
            load   = 1'b0;
         end
         if (rst_edge != 0 && edges == rst_edge && !rst_hit) begin
            rst     = 1'b1;
            rst_hit = 1'b1;
         end
         @(negedge clk);
      end
      done_end = done;
      if (rst_hit) begin
         check("rst_mid_cs", {31'b0, cs_n}, 32'd1);
         check("rst_mid_sclk", {31'b0, sclk}, 32'd0);
         check("rst_mid_busy", {31'b0, busy}, 32'd0);
         check("rst_mid_done", {31'b0, done}, 32'd0);
         rst = 1'b0;
         @(negedge clk);
         check("rst_after_done", {31'b0, done}, 32'd0);
      end
      gap_ok = 1'b0;
      if (b2b) begin
         sample = smp2;
         load   = 1'b1;
         @(negedge clk);
         load   = 1'b0;
         gap_ok = ~cs_n;
      end
   endtask

   initial begin
      // Reset held with load high
      rst = 1'b1; load = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_sclk", {31'b0, sclk_a | sclk_b}, 32'd0);
      end
      check("rst_outs_a", {26'b0, cs_a, sclk_a, mosi_a, busy_a, done_a, ovr_a}, 32'h20);
      check("rst_outs_b", {26'b0, cs_b, sclk_b, mosi_b, busy_b, done_b, ovr_b}, 32'h20);
      rst = 1'b0; load = 1'b0;
      @(negedge clk);
      check("idle_outs", {26'b0, cs_a, sclk_a, mosi_a, busy_a, done_a, ovr_a}, 32'h20);

      // Single frame followed by back-to-back load in the done cycle
      frame(1'b1, 12'hABC, 0, 0, 1'b1, 12'h001);
      check("abc_word", word, 32'h003FABC0);
      check("abc_cs_len", cs_len, 32'd65);
      check("abc_edges", edges, 32'd32);
      check("abc_done_mid", dones_mid, 32'd0);
      check("abc_done_end", {31'b0, done_end}, 32'd1);
      check("b2b_gap", {31'b0, gap_ok}, 32'd1);
      frame(1'b0, 12'h001, 0, 0, 1'b0, 12'h000);
      check("b2b_word", word, 32'h003F0010);
      check("b2b_cs_len", cs_len, 32'd65);
      check("b2b_done_end", {31'b0, done_end}, 32'd1);
      check("b2b_ovr", {31'b0, ovr}, 32'd0);
      repeat (3) @(negedge clk);
      check("idle_busy", {31'b0, busy}, 32'd0);

      // Overrun: second load at cycle 20 of the frame
      frame(1'b1, 12'h123, 20, 0, 1'b0, 12'h000);
      check("ovr_word", word, 32'h003F1230);
      check("ovr_cs_len", cs_len, 32'd65);
      check("ovr_edges", edges, 32'd32);
      repeat (2) @(negedge clk);
      frame(1'b1, 12'h456, 0, 0, 1'b0, 12'h000);
      check("ovr_next_word", word, 32'h003F4560);
      check("ovr_sticky", {31'b0, ovr}, 32'd1);

      // Reset in the middle of bit 10
      repeat (2) @(negedge clk);
      frame(1'b1, 12'h5A5, 0, 22, 1'b0, 12'h000);
      check("rst_mid_edges", edges, 32'd22);
      check("rst_ovr_clear", {31'b0, ovr}, 32'd0);
      frame(1'b1, 12'h7E1, 0, 0, 1'b0, 12'h000);
      check("post_rst_word", word, 32'h003F7E10);
      check("post_rst_cs_len", cs_len, 32'd65);
      check("post_rst_done", {31'b0, done_end}, 32'd1);

      // CLK_DIV=3 instance
      repeat (2) @(negedge clk);
      sel = 1'b1;
      frame(1'b1, 12'h800, 0, 0, 1'b0, 12'h000);
      check("div3_word", word, 32'h003F8000);
      check("div3_cs_len", cs_len, 32'd195);
      check("div3_edges", edges, 32'd32);
      check("div3_hi_max", hi_max, 32'd3);
      check("div3_lo_max", lo_max, 32'd3);
      check("div3_hi_total", hi_total, 32'd96);
      check("div3_done_end", {31'b0, done_end}, 32'd1);
      check("div3_ovr", {31'b0, ovr}, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
